// File: rtl/uart_tx_periph_if.sv
// Simple SoC bus port for the UART TX peripheral: word address, write data,
// write strobe and combinational read data.
interface uart_tx_periph_if;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic [31:0] rdata;

    modport master (output addr, output wdata, output we, input rdata);
    modport slave  (input addr, input wdata, input we, output rdata);
endinterface

// File: rtl/uart_tx_periph.sv
// Memory-mapped 8N1 UART transmitter: TX FIFO fed by bus stores, baud-rate
// serialiser, status/divider/control registers and a TX-drained interrupt.
module uart_tx_periph #(
    parameter int          FIFO_DEPTH  = 4,
    parameter logic [15:0] DEFAULT_DIV = 16'd434
) (
    input  logic              clk,
    input  logic              rst,
    uart_tx_periph_if.slave   bus,
    output logic              tx_out,
    output logic              irq
);
    localparam int           AW       = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]  DEPTH_P  = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0]  PTR_ONE  = (AW+1)'(1);
    localparam logic [AW:0]  PTR_ZERO = (AW+1)'(0);
    localparam logic [1:0]   ST_IDLE  = 2'd0;
    localparam logic [1:0]   ST_START = 2'd1;
    localparam logic [1:0]   ST_DATA  = 2'd2;
    localparam logic [1:0]   ST_STOP  = 2'd3;

    logic [7:0]  mem_r [FIFO_DEPTH];
    logic [AW:0] wr_ptr_r, rd_ptr_r, count_s;
    logic        full_s, empty_s, ovf_r;
    logic [15:0] div_r, div_eff_s, reload_s;
    logic [1:0]  ctrl_r;
    logic [1:0]  state_r, state_nxt_s;
    logic [15:0] cnt_r, cnt_nxt_s;
    logic [7:0]  shift_r, shift_nxt_s, head_s;
    logic [2:0]  bit_idx_r, bit_nxt_s;
    logic        pop_s, tx_nxt_s, tx_r, irq_r;
    logic [1:0]  sel_s;
    logic        data_we_s, stat_we_s, div_we_s, ctrl_we_s, push_ok_s;
    logic [31:0] count_ext_s, status_s;
    logic [2:0]  count_sat_s;
    logic        unused_s;

    assign sel_s     = bus.addr[3:2];
    assign data_we_s = bus.we && (sel_s == 2'd0);
    assign stat_we_s = bus.we && (sel_s == 2'd1);
    assign div_we_s  = bus.we && (sel_s == 2'd2);
    assign ctrl_we_s = bus.we && (sel_s == 2'd3);
    assign unused_s  = ^{bus.addr[31:4], bus.addr[1:0], bus.wdata[31:16]};

    assign count_s   = wr_ptr_r - rd_ptr_r;
    assign full_s    = (count_s == DEPTH_P);
    assign empty_s   = (count_s == PTR_ZERO);
    assign head_s    = mem_r[rd_ptr_r[AW-1:0]];
    // A pop in the same cycle frees the slot, so a push into a full FIFO is still accepted
    assign push_ok_s = data_we_s && (!full_s || pop_s);

    assign div_eff_s = (div_r == 16'd0) ? 16'd1 : div_r;
    assign reload_s  = div_eff_s - 16'd1;

    // FIFO storage, pointers and sticky overflow flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem_r[i] <= 8'd0;
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
            ovf_r    <= 1'b0;
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r[AW-1:0]] <= bus.wdata[7:0];
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) rd_ptr_r <= rd_ptr_r + PTR_ONE;
            if (stat_we_s) ovf_r <= 1'b0;
            else if (data_we_s && full_s && !pop_s) ovf_r <= 1'b1;
        end
    end

    // Divider and control registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_r  <= DEFAULT_DIV;
            ctrl_r <= 2'd0;
        end else begin
            if (div_we_s)  div_r  <= bus.wdata[15:0];
            if (ctrl_we_s) ctrl_r <= bus.wdata[1:0];
        end
    end

    // Serialiser next-state: the baud counter reloads from DIV only at bit boundaries
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        shift_nxt_s = shift_r;
        bit_nxt_s   = bit_idx_r;
        pop_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (ctrl_r[0] && !empty_s) begin
                    pop_s       = 1'b1;
                    shift_nxt_s = head_s;
                    cnt_nxt_s   = reload_s;
                    state_nxt_s = ST_START;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (cnt_r == 16'd0) begin
                    cnt_nxt_s   = reload_s;
                    bit_nxt_s   = 3'd0;
                    state_nxt_s = ST_DATA;
                end else begin
                    cnt_nxt_s = cnt_r - 16'd1;
                end
            end
            ST_DATA: begin
                if (cnt_r == 16'd0) begin
                    cnt_nxt_s   = reload_s;
                    shift_nxt_s = {1'b0, shift_r[7:1]};
                    if (bit_idx_r == 3'd7) begin
                        state_nxt_s = ST_STOP;
                    end else begin
                        bit_nxt_s = bit_idx_r + 3'd1;
                    end
                end else begin
                    cnt_nxt_s = cnt_r - 16'd1;
                end
            end
            ST_STOP: begin
                if (cnt_r == 16'd0) begin
                    if (ctrl_r[0] && !empty_s) begin
                        pop_s       = 1'b1;
                        shift_nxt_s = head_s;
                        cnt_nxt_s   = reload_s;
                        state_nxt_s = ST_START;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end else begin
                    cnt_nxt_s = cnt_r - 16'd1;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Line level for the state being entered, so tx_out is registered without lag
    always_comb begin
        tx_nxt_s = 1'b1;
        case (state_nxt_s)
            ST_IDLE:  tx_nxt_s = 1'b1;
            ST_START: tx_nxt_s = 1'b0;
            ST_DATA:  tx_nxt_s = shift_nxt_s[0];
            ST_STOP:  tx_nxt_s = 1'b1;
            default:  tx_nxt_s = 1'b1;
        endcase
    end

    // Serialiser state and registered serial line
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= ST_IDLE;
            cnt_r     <= 16'd0;
            shift_r   <= 8'd0;
            bit_idx_r <= 3'd0;
            tx_r      <= 1'b1;
        end else begin
            state_r   <= state_nxt_s;
            cnt_r     <= cnt_nxt_s;
            shift_r   <= shift_nxt_s;
            bit_idx_r <= bit_nxt_s;
            tx_r      <= tx_nxt_s;
        end
    end

    // Drained interrupt; an accepted push or clearing irq enable drops it at once
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            irq_r <= 1'b0;
        end else begin
            irq_r <= ctrl_r[1] && (state_r == ST_IDLE) && empty_s && !push_ok_s
                     && !(ctrl_we_s && !bus.wdata[1]);
        end
    end

    assign count_ext_s = 32'(count_s);
    assign count_sat_s = (count_ext_s > 32'd7) ? 3'd7 : count_ext_s[2:0];
    assign status_s    = {25'd0, ovf_r, count_sat_s, empty_s, full_s, (state_r != ST_IDLE)};

    // Register read mux
    always_comb begin
        bus.rdata = 32'd0;
        case (sel_s)
            2'd0:    bus.rdata = 32'd0;
            2'd1:    bus.rdata = status_s;
            2'd2:    bus.rdata = {16'd0, div_r};
            2'd3:    bus.rdata = {30'd0, ctrl_r};
            default: bus.rdata = 32'd0;
        endcase
    end

    assign tx_out = tx_r;
    assign irq    = irq_r;
endmodule

// File: doc/uart_tx_periph.md
# uart_tx_periph

Memory-mapped UART transmitter peripheral that hangs off the SoC's simple bus beside the GPIO and PWM blocks. The CPU writes bytes into a small TX FIFO through bus stores. A baud-rate state machine serialises each byte onto `tx_out` as 8N1 frames, LSB first. It reports status and raises a level interrupt when the transmitter drains.

## Interface
- `FIFO_DEPTH`, default 4: TX FIFO entries; power of two, minimum 2.
- `DEFAULT_DIV`, default 16'd434: reset value of the DIV register, in clocks per bit.
- `clk`  input  1  system clock; all state changes on the rising edge.
- `rst`  input  1  asynchronous, active-low reset.
- `addr`  input  32  bus address. Only `addr[3:2]` is decoded; base decoding is done by the bus.
- `wdata`  input  32  bus write data.
- `we`  input  1  write strobe, sampled at the rising edge.
- `rdata`  output  32  read data; combinational from `addr[3:2]` and current state.
- `tx_out`  output  1  serial line, registered; idles high.
- `irq`  output  1  TX-done interrupt, registered level.

## Operation
Register map (offsets from the peripheral base):
- 0x0 DATA
  - Write pushes `wdata[7:0]` into the FIFO.
  - Read returns 0.
- 0x4 STATUS (read-only fields)
  - bit0: busy, i.e. the FSM is not IDLE.
  - bit1: FIFO full.
  - bit2: FIFO empty.
  - bits[5:3]: FIFO count, saturating at 7.
  - bit6: overflow, sticky.
  - Any write to STATUS clears overflow.
- 0x8 DIV
  - `[15:0]` gives clocks per bit. A value of 0 is treated as 1.
  - Reads return the stored value.
- 0xC CTRL
  - bit0: enable.
  - bit1: irq enable.
  - Reset value is 0.

FIFO:
- Circular buffer with `log2(FIFO_DEPTH)+1`-bit read and write pointers; pointers wrap modulo 2·depth.
- A push when full is dropped and sets overflow.
- A push and a pop in the same cycle while full is accepted: the count is unchanged and no overflow is set.
- A push and a pop in the same cycle while empty is not possible, because a pop requires the FIFO to be non-empty before the edge.

FSM states:
- IDLE: `tx_out`=1. If enable=1 and the FIFO is non-empty:
  - pop the head into the shift register;
  - load the baud counter with DIV-1;
  - go to START.
- START: `tx_out`=0. When the baud counter reaches 0, reload it, clear the bit index, and go to DATA.
- DATA: `tx_out` = shift[0]. At each counter expiry, shift right and increment the bit index. After bit 7 expires, go to STOP.
- STOP: `tx_out`=1 for DIV cycles. On expiry:
  - if enable=1 and the FIFO is non-empty, pop and go directly to START (back-to-back frames, no idle bit);
  - otherwise go to IDLE.

Other behaviour:
- Clearing enable mid-frame: the current frame completes and the FSM then stays in IDLE. FIFO contents are retained.
- A DIV write mid-frame takes effect at the next counter reload, i.e. at the next bit boundary.
- `irq` is set when CTRL.bit1=1, the FSM is IDLE and the FIFO is empty.
  - It is registered, so it follows these conditions with a one-cycle delay.
  - It clears when a DATA write is accepted or when the irq enable is cleared.
- Reset (asserted asynchronously, including mid-frame):
  - `tx_out`=1 immediately;
  - `irq`=0;
  - FIFO flushed, with pointers 0;
  - overflow 0;
  - DIV=DEFAULT_DIV;
  - CTRL=0;
  - FSM in IDLE.

## Timing
- Write at edge E0: the FIFO count reflects the write after E0.
- With enable=1 and the FSM IDLE, the pop happens at E1 and `tx_out` goes low after E1. Write-to-start-bit latency is 1 cycle after the write.
- Each bit lasts exactly max(DIV,1) cycles, so a frame is 10·max(DIV,1) cycles.
- Back-to-back frames have zero gap: the next start bit begins on the cycle after the last stop-bit cycle.
- `rdata` is valid in the same cycle as `addr`, with no wait states. STATUS reads reflect state after the most recent edge.

## Test plan
- Reset, then read all registers: STATUS=0x04, DIV=434, CTRL=0, `tx_out`=1, `irq`=0.
- DIV=4, CTRL=1, write 0xA5:
  - `tx_out` shows 0 for 4 cycles, then bits 1,0,1,0,0,1,0,1, 4 cycles each, then 1.
  - busy clears 40 cycles after the start bit began.
- DIV=2, enable=0, write 5 bytes:
  - the 5th is dropped, STATUS bit6=1, count=4;
  - a write to STATUS clears bit6.
  - Then enable=1: 4 frames go out back-to-back with no idle cycle between them.
- CTRL=3 with an empty FIFO: `irq`=1. A DATA write drops `irq` the next cycle; `irq` reasserts one cycle after the final stop bit completes.
- During DATA bit 3, change DIV from 4 to 8: the current bit still lasts 4 cycles, and subsequent bits last 8.
- Assert `rst` mid-frame: `tx_out`=1 asynchronously. After release STATUS=0x04 and no further frame is sent.
